// File: rtl/add_arbiter_pkg.sv
// ============================================================================
//  Module      : add_arbiter_pkg
//  Description : Shared constants and slot-state encoding for add_arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package add_arbiter_pkg;

    localparam int ADD_W    = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/add.sv
// ============================================================================
//  Module      : add
//  Description : Shared 8-bit combinational adder, c = (a + b) mod 256.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module add (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] c
);

    assign c = a + b;

endmodule

`default_nettype wire

// File: rtl/add_arbiter_rr_pick.sv
// ============================================================================
//  Module      : add_arbiter_rr_pick
//  Description : Rotating-priority encoder; first valid requester after rr_ptr.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module add_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_valid
);

    // Priority distance of requester i is its position after rr_ptr (0 = next in line).
    always_comb begin
        int best_d;
        int d;
        grant     = '0;
        any_valid = 1'b0;
        best_d    = NREQ;
        d         = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(rr_ptr) - 1 + 2 * NREQ) % NREQ;
            if (req_valid[i] && (d < best_d)) begin
                best_d    = d;
                grant     = IDW'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_arbiter.sv
// ============================================================================
//  Module      : add_arbiter
//  Description : Round-robin sharing of one 8-bit adder with a one-entry result slot.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic [CNTW-1:0]       ops_done
);

    if (IDW != $clog2(NREQ)) begin : g_idw_chk
        $error("add_arbiter: IDW must equal clog2(NREQ)");
    end
    if ((NREQ < 2) || (NREQ > 8)) begin : g_nreq_chk
        $error("add_arbiter: NREQ must be in 2..8");
    end

    slot_state_t      state_q, state_d;
    logic [ADD_W-1:0] sum_q, sum_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]  ops_q, ops_d;

    logic [IDW-1:0]   w_grant;
    logic             w_any_valid;
    logic [ADD_W-1:0] w_a;
    logic [ADD_W-1:0] w_b;
    logic [ADD_W-1:0] w_sum;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_drain;

    add_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (w_grant),
        .any_valid (w_any_valid)
    );

    always_comb begin
        w_a = req_a[int'(w_grant)*ADD_W +: ADD_W];
        w_b = req_b[int'(w_grant)*ADD_W +: ADD_W];
    end

    add u_add (
        .a (w_a),
        .b (w_b),
        .c (w_sum)
    );

    assign w_slot_free = (state_q == ST_EMPTY) || rsp_ready;
    assign w_drain     = (state_q == ST_FULL) && rsp_ready;

    // Grant is qualified by rst so no operand is taken while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && w_any_valid && w_slot_free) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept = |(req_valid & req_ready);

    // Accept after drain so a same-cycle reload keeps the slot full.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        ops_d    = ops_q;
        if (w_drain) begin
            state_d = ST_EMPTY;
            if (ops_q != '1) begin
                ops_d = ops_q + CNTW'(1);
            end
        end
        if (w_accept) begin
            state_d  = ST_FULL;
            sum_d    = w_sum;
            id_d     = w_grant;
            rr_ptr_d = w_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            sum_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= IDW'(NREQ - 1);
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            ops_q    <= ops_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign ops_done  = ops_q;

endmodule

`default_nettype wire

// File: tb/tb_add_arbiter.sv
// ============================================================================
//  Module      : tb_add_arbiter
//  Description : Randomized scoreboard bench for add_arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_add_arbiter;
    import add_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADD_W-1:0] req_a;
    logic [NREQ*ADD_W-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [ADD_W-1:0]      rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
    logic [CNTW-1:0]       ops_done;

    always #5 clk = ~clk;

    add_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .ops_done  (ops_done)
    );

    typedef struct {
        logic [7:0] sum;
        int         id;
    } rsp_t;

    rsp_t       exp_q[$];
    int         ids_seen[$];
    int         checks = 0;
    int         errors = 0;
    bit         v[NREQ];
    logic [7:0] a[NREQ];
    logic [7:0] b[NREQ];
    int         m_ptr;
    int         m_ops;
    bit         mon_en = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_sum;
    logic [IDW-1:0] prev_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit any_v();
        for (int i = 0; i < NREQ; i++) if (v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input int i, input logic [7:0] av, input logic [7:0] bv);
        if (!v[i]) begin
            v[i] = 1'b1;
            a[i] = av;
            b[i] = bv;
        end
    endtask

    // One cycle: drive inputs, then predict the grant from the round-robin rule.
    task automatic step(input logic r);
        int g;
        logic [NREQ-1:0] exp_rdy;
        rsp_t e;
        @(negedge clk);
        rsp_ready = r;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = v[i];
            req_a[i*8 +: 8]    = a[i];
            req_b[i*8 +: 8]    = b[i];
        end
        #2;
        g = -1;
        if (exp_q.size() == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        if (g >= 0) begin
            e.sum = 8'((int'(a[g]) + int'(b[g])) % 256);
            e.id  = g;
            exp_q.push_back(e);
            m_ptr = g;
            v[g]  = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || any_v()) && n < 60) begin
            step(1'b1);
            n++;
        end
        if (exp_q.size() != 0 || any_v()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        step(1'b1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_sum",   {24'd0, rsp_sum},   32'd0);
        chk("rst_rsp_id",    {30'd0, rsp_id},    32'd0);
        chk("rst_ops_done",  {16'd0, ops_done},  32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        exp_q.delete();
        m_ptr = NREQ - 1;
        m_ops = 0;
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        mon_en    = 1'b1;
    endtask

    // Monitor: compares the result slot against the head of the scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() != 0});
                chk("ops_done", {16'd0, ops_done}, 32'(m_ops));
                if (hold_prev && exp_q.size() != 0) begin
                    chk("hold_sum", {24'd0, rsp_sum}, {24'd0, prev_sum});
                    chk("hold_id",  {30'd0, rsp_id},  {30'd0, prev_id});
                end
                if (exp_q.size() != 0) begin
                    hold_prev = !rsp_ready;
                    prev_sum  = rsp_sum;
                    prev_id   = rsp_id;
                    if (rsp_ready) begin
                        e = exp_q.pop_front();
                        chk("rsp_sum", {24'd0, rsp_sum}, {24'd0, e.sum});
                        chk("rsp_id",  {30'd0, rsp_id},  32'(e.id));
                        ids_seen.push_back(int'(rsp_id));
                        if (m_ops < (1 << CNTW) - 1) m_ops++;
                    end
                end else begin
                    hold_prev = 1'b0;
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        m_ptr = NREQ - 1;
        m_ops = 0;
        do_reset();

        // Single request
        set_req(0, 8'h12, 8'h34);
        drain();

        // All four requesters from fresh reset priority
        do_reset();
        ids_seen.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i), 8'h10);
        drain();
        for (int k = 0; k < NREQ; k++) begin
            if (k < ids_seen.size()) chk("all4_order", 32'(ids_seen[k]), 32'(k));
        end

        // Backpressure with requesters 1 and 2
        set_req(1, 8'h21, 8'h02);
        set_req(2, 8'h40, 8'h05);
        repeat (5) step(1'b0);
        drain();

        // Wrap-around arithmetic
        set_req(3, 8'hFF, 8'h01); drain();
        set_req(3, 8'h80, 8'h80); drain();
        set_req(3, 8'h7F, 8'h01); drain();

        // Fairness between requesters 0 and 2
        ids_seen.delete();
        repeat (20) begin
            set_req(0, 8'($urandom), 8'($urandom));
            set_req(2, 8'($urandom), 8'($urandom));
            step(1'b1);
        end
        drain();
        for (int k = 1; k < ids_seen.size(); k++) begin
            chk("fair_alternate", {31'd0, ids_seen[k] == ids_seen[k-1]}, 32'd0);
        end

        // Random traffic
        repeat (1500) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 99) < 40) set_req(i, 8'($urandom), 8'($urandom));
            end
            step($urandom_range(0, 3) != 0);
        end
        drain();

        // Reset while the slot is full and stalled
        set_req(1, 8'h55, 8'h11);
        step(1'b0);
        step(1'b0);
        mon_en = 1'b0;
        req_valid = '1;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ops_done",  {16'd0, ops_done},  32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        exp_q.delete();
        m_ptr = NREQ - 1;
        m_ops = 0;
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        mon_en    = 1'b1;
        ids_seen.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 3), 8'h01);
        drain();
        if (ids_seen.size() > 0) chk("midrst_first_grant", 32'(ids_seen[0]), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one 8-bit combinational adder (the existing `add` module: A+B→C, mod 256) among NREQ requesters.
- Round-robin arbitration, valid/ready handshake on every requester port, one registered response port with a one-entry output slot.
- Sits between the instruction-execution units and the shared adder so address-increment, ALU and loop-count units do not each need their own adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width; must equal clog2(NREQ), checked at elaboration.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*8  operand A, requester i at bits [8i+7:8i].
- req_b  in  NREQ*8  operand B, same packing.
- req_ready  out  NREQ  one-hot or zero; requester i's operands accepted this cycle.
- rsp_valid  out  1  result slot holds a result.
- rsp_sum  out  8  (a+b) mod 256 of the accepted request.
- rsp_id  out  IDW  index of the requester that owns rsp_sum.
- rsp_ready  in  1  consumer takes the result this cycle.
- ops_done  out  CNTW  count of completed responses, saturating.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, ops_done=0, rr_ptr=NREQ-1.
  - Requester 0 therefore has first priority after reset.
  - req_ready forced to 0 while rst=1.
- Slot state (FSM):
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - slot_free = EMPTY, or (FULL and rsp_ready).
- Arbitration (combinational each cycle):
  - Scan req_valid starting at rr_ptr+1, wrapping modulo NREQ.
  - The first set bit is the grant g.
  - req_ready[g] = slot_free. All other req_ready bits are 0.
  - If no req_valid bit is set, req_ready=0.
- Accept (req_valid[g] & req_ready[g]) at edge N:
  - rsp_sum <= add(req_a[g], req_b[g]); rsp_id <= g; rsp_valid <= 1; rr_ptr <= g.
  - rsp_valid is 1 in cycle N+1, so latency is 1 cycle.
- Drain (rsp_valid & rsp_ready) without a simultaneous accept:
  - Next state EMPTY; rsp_sum and rsp_id hold their last values.
- Simultaneous drain and accept:
  - Slot is reloaded with the new result; rsp_valid stays 1.
  - Throughput is 1 op/cycle while rsp_ready=1.
- Backpressure (FULL, rsp_ready=0):
  - rsp_sum, rsp_id and rsp_valid hold stable.
  - req_ready=0; rr_ptr does not move.
- Requester obligation:
  - Once req_valid is asserted, the requester holds req_valid and its operands until req_ready.
  - The arbiter does not latch an ungranted request.
- rr_ptr changes only on accept. An idle cycle does not rotate priority.
- Arithmetic:
  - Unsigned 8-bit; carry discarded. 0xFF+0x01=0x00 with no flag.
- ops_done:
  - Increments on each drain handshake.
  - Saturates at 2^CNTW-1 and does not wrap.
- Reset mid-operation:
  - Any held result is discarded and rsp_valid drops immediately (asynchronously).
  - Priority returns to requester 0.

Decomposition:
- Shared package holds: ADD_W=8, the default NREQ, and the slot-state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1).
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req_valid[NREQ], rr_ptr.
  - Outputs: grant index, any_valid.
- The datapath reuses the existing `add` module; no new adder RTL.

Test Plan:
- Single request: reset, then req_valid=0b0001 with a0=0x12, b0=0x34 and rsp_ready=1.
  - req_ready=0b0001 for 1 cycle.
  - Next cycle rsp_valid=1, rsp_sum=0x46, rsp_id=0; ops_done=1 after the drain.
- All four requesters valid, operands (i, 0x10) for i=0..3, rsp_ready=1.
  - Grants in order 0,1,2,3 on consecutive cycles.
  - rsp_sum=0x10,0x11,0x12,0x13 with matching rsp_id; no idle cycles.
- Backpressure: rsp_ready=0 for 5 cycles with requesters 1 and 2 valid.
  - Exactly one accept; rsp_sum and rsp_id stable across all 5 cycles; req_ready=0 after the first accept.
  - Raise rsp_ready: the other requester is accepted in the same cycle as the drain.
- Wrap-around: a=0xFF, b=0x01 gives rsp_sum=0x00; a=0x80, b=0x80 gives 0x00; a=0x7F, b=0x01 gives 0x80.
- Fairness: requester 0 continuously valid and requester 2 continuously valid.
  - Grants alternate 0,2,0,2; neither requester waits more than 1 accept.
- Reset mid-operation: assert rst while FULL and rsp_ready=0.
  - rsp_valid drops before the next edge and ops_done=0.
  - After release, with all requesters valid, the first grant goes to requester 0.
